key_debounce: RTL and testbench

//  Front-end conditioner for a raw push-button pin. Synchronises the asynchronous pin

---
 rtl/key_pkg.sv | 22 ++
 rtl/sync_ff.sv | 38 +++
 rtl/key_debounce.sv | 139 +++++++++++++
 tb/tb_key_debounce.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared types and helpers for the push-button front end and the downstream
// short/long key classifier.
//   key_db_state_t : debounce FSM state encoding
//   ms_to_cycles   : converts a time in ms to clock cycles at a given clk rate
// -----------------------------------------------------------------------------
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_db_state_t;

  // Divide first so the intermediate stays within 32 bits for MHz-range clocks.
  function automatic int ms_to_cycles(input int hz, input int ms);
    return ms * (hz / 1000);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Generic N-flop synchroniser for a single asynchronous bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, loads RST_VAL into every stage
//   d   : asynchronous input
//   q   : synchronised output (last stage)
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Stage 0 captures the pin; each later stage copies its predecessor.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Conditions a raw push-button pin: synchronises it into clk, then requires the
// pressed/released level to be stable for CNT_TH consecutive cycles before the
// clean level changes. One-cycle strobes mark each accepted press and release.
//   clk         : system clock, all logic on posedge
//   rst         : asynchronous active-high reset
//   in_btn      : raw button pin, asynchronous to clk
//   out_key     : debounced level, 1 = pressed
//   out_press   : one-cycle strobe on the edge out_key rises
//   out_release : one-cycle strobe on the edge out_key falls
// Handshake: none; strobes are unqualified single-cycle pulses, valid on the
// clock edge where out_key changes, and have no back-pressure.
// -----------------------------------------------------------------------------
module key_debounce
  import key_pkg::*;
#(
  parameter int IN_C_HZ     = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_btn,
  output logic out_key,
  output logic out_press,
  output logic out_release
);

  localparam int CNT_TH = ms_to_cycles(IN_C_HZ, DEBOUNCE_MS);
  localparam int CNT_W  = (CNT_TH < 1) ? 1 : $clog2(CNT_TH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_TH - 1);

  if (CNT_TH < 1) begin : g_bad_cnt_th
    $error("key_debounce: debounce threshold must be at least one cycle");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_debounce: SYNC_STAGES must be at least 2");
  end

  logic sync_pin;
  logic s_pressed;

  // The chain resets to the released pin level so no false press appears.
  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_btn),
    .q   (sync_pin)
  );

  assign s_pressed = sync_pin ^ ACTIVE_LOW;

  key_db_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_pressed) begin
          // Bounce back to released: drop silently and start over.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          key_d   = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s_pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s_pressed) begin
          // Short release glitch: the key never left the pressed level.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          key_d     = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        key_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign out_key     = key_q;
  assign out_press   = press_q;
  assign out_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
// Two instances share one logical button: dut_a is active-low, dut_b is
// active-high and receives the inverted pin, so both must behave identically.
// A behavioural model predicts every accepted press/release; the monitor pops
// those predictions as the DUTs emit strobes.
// -----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int CNT_TH = 5;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + 1 + CNT_TH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic in_btn_a = 1'b1;
  logic in_btn_b = 1'b0;
  logic out_key_a, out_press_a, out_release_a;
  logic out_key_b, out_press_b, out_release_b;

  key_debounce #(
    .IN_C_HZ (1000), .DEBOUNCE_MS (5), .SYNC_STAGES (SYNC), .ACTIVE_LOW (1'b1)
  ) dut_a (
    .clk (clk), .rst (rst), .in_btn (in_btn_a),
    .out_key (out_key_a), .out_press (out_press_a), .out_release (out_release_a)
  );

  key_debounce #(
    .IN_C_HZ (1000), .DEBOUNCE_MS (5), .SYNC_STAGES (SYNC), .ACTIVE_LOW (1'b0)
  ) dut_b (
    .clk (clk), .rst (rst), .in_btn (in_btn_b),
    .out_key (out_key_b), .out_press (out_press_b), .out_release (out_release_b)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int press_cnt [2];
  int rel_cnt   [2];
  int last_press[2];
  int last_rel  [2];
  bit last_is_press[2];

  // Expected strobes: {is_press, cycle}
  logic [32:0] exp_q_a[$];
  logic [32:0] exp_q_b[$];

  // ---------------- reference model ----------------
  // The FSM sees the pin SYNC edges late. The key flips once it has seen
  // CNT_TH+1 consecutive samples at the opposite level.
  bit seen_pipe[$];
  bit run_q[$];
  bit mdl_key;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mdl_reset();
    seen_pipe.delete();
    for (int i = 0; i < SYNC; i++) seen_pipe.push_back(1'b0);
    run_q.delete();
    mdl_key = 1'b0;
    exp_q_a.delete();
    exp_q_b.delete();
    last_is_press[0] = 1'b0;
    last_is_press[1] = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit seen;
    if (clk) cyc++;
    if (rst) begin
      mdl_reset();
    end else begin
      seen = seen_pipe.pop_front();
      seen_pipe.push_back(in_btn_a == 1'b0);
      if (seen == mdl_key) run_q.delete();
      else run_q.push_back(seen);
      if (run_q.size() == CNT_TH + 1) begin
        mdl_key = ~mdl_key;
        run_q.delete();
        exp_q_a.push_back({mdl_key, 32'(cyc)});
        exp_q_b.push_back({mdl_key, 32'(cyc)});
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  function automatic int q_size(input int inst);
    return (inst == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  function automatic logic [32:0] q_front(input int inst);
    return (inst == 0) ? exp_q_a[0] : exp_q_b[0];
  endfunction

  task automatic q_pop(input int inst, output logic [32:0] e);
    if (inst == 0) e = exp_q_a.pop_front();
    else           e = exp_q_b.pop_front();
  endtask

  task automatic mon(input int inst, input logic k, input logic p, input logic r);
    logic [32:0] e;
    int          ecyc;
    string       tg;
    tg = (inst == 0) ? "a" : "b";
    chk({"key_level_", tg}, 64'(k), 64'(mdl_key));
    while (q_size(inst) > 0) begin
      e    = q_front(inst);
      ecyc = int'(e[31:0]);
      if (ecyc >= cyc) break;
      q_pop(inst, e);
      n_checks++;
      n_fail++;
      $display("FAIL missing_strobe_%s: got no strobe, required one at cycle %0d (now %0d)",
               tg, ecyc, cyc);
    end
    if (p || r) begin
      chk({"no_overlap_", tg}, 64'(p & r), 64'd0);
      chk({"alternate_", tg}, 64'(p), 64'(!last_is_press[inst]));
      last_is_press[inst] = p;
      if (p) begin
        press_cnt[inst]++;
        last_press[inst] = cyc;
      end else begin
        rel_cnt[inst]++;
        last_rel[inst] = cyc;
      end
      if (q_size(inst) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_strobe_%s: got press=%0b release=%0b at cycle %0d, required none",
                 tg, p, r, cyc);
      end else begin
        q_pop(inst, e);
        chk({"strobe_kind_", tg}, 64'(p), 64'(e[32]));
        chk({"strobe_cycle_", tg}, 64'(cyc), 64'(e[31:0]));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, out_key_a, out_press_a, out_release_a);
      mon(1, out_key_b, out_press_b, out_release_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_pin(input bit pressed);
    in_btn_a = ~pressed;
    in_btn_b = pressed;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Short async reset pulse inside the low clock phase, outputs checked at once.
  task automatic rst_pulse(input string name);
    #2 rst = 1'b1;
    #1;
    chk({name, "_a"}, 64'({out_key_a, out_press_a, out_release_a}), 64'd0);
    chk({name, "_b"}, 64'({out_key_b, out_press_b, out_release_b}), 64'd0);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int c0;
    int pc0;
    int rc0;
    int hold;
    for (int i = 0; i < 2; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; last_press[i] = -1; last_rel[i] = -1;
    end
    mdl_reset();
    set_pin(1'b0);
    rst = 1'b1;

    // Reset held with pin released.
    repeat (20) begin
      @(negedge clk); #1;
      chk("reset_out_a", 64'({out_key_a, out_press_a, out_release_a}), 64'd0);
      chk("reset_out_b", 64'({out_key_b, out_press_b, out_release_b}), 64'd0);
    end
    rst = 1'b0;
    tick(20);
    chk("idle_no_strobe", 64'(press_cnt[0] + rel_cnt[0] + press_cnt[1] + rel_cnt[1]), 64'd0);

    // Clean press: strobe exactly LAT edges later.
    @(negedge clk); set_pin(1'b1); c0 = cyc; pc0 = press_cnt[0];
    repeat (LAT - 1) @(negedge clk); #1;
    chk("press_early_a", 64'(out_key_a), 64'd0);
    @(negedge clk); #1;
    chk("press_key_a", 64'(out_key_a), 64'd1);
    chk("press_strobe_a", 64'(out_press_a), 64'd1);
    chk("press_strobe_b", 64'(out_press_b), 64'd1);
    chk("press_lat_a", 64'(last_press[0]), 64'(c0 + LAT));
    chk("press_lat_b", 64'(last_press[1]), 64'(c0 + LAT));
    @(negedge clk); #1;
    chk("press_strobe_low_a", 64'(out_press_a), 64'd0);
    tick(20);
    chk("press_once_a", 64'(press_cnt[0] - pc0), 64'd1);

    // Clean release.
    @(negedge clk); set_pin(1'b0); c0 = cyc;
    repeat (LAT) @(negedge clk); #1;
    chk("release_key_a", 64'(out_key_a), 64'd0);
    chk("release_strobe_a", 64'(out_release_a), 64'd1);
    chk("release_lat_a", 64'(last_rel[0]), 64'(c0 + LAT));
    chk("release_lat_b", 64'(last_rel[1]), 64'(c0 + LAT));
    tick(20);

    // Bounce: pressed 3 cycles, released 1, then pressed and held.
    @(negedge clk); set_pin(1'b1);
    tick(3); set_pin(1'b0);
    tick(1); set_pin(1'b1); c0 = cyc; pc0 = press_cnt[0];
    repeat (LAT - 1) @(negedge clk); #1;
    chk("bounce_early_a", 64'(out_key_a), 64'd0);
    @(negedge clk); #1;
    chk("bounce_key_a", 64'(out_key_a), 64'd1);
    chk("bounce_lat_a", 64'(last_press[0]), 64'(c0 + LAT));
    tick(20);
    chk("bounce_once_a", 64'(press_cnt[0] - pc0), 64'd1);
    chk("bounce_once_b", 64'(press_cnt[1] - pc0), 64'd1);

    // Two-cycle release glitch while pressed.
    rc0 = rel_cnt[0];
    @(negedge clk); set_pin(1'b0);
    tick(2); set_pin(1'b1);
    tick(20); #1;
    chk("glitch_key_a", 64'(out_key_a), 64'd1);
    chk("glitch_key_b", 64'(out_key_b), 64'd1);
    chk("glitch_no_rel_a", 64'(rel_cnt[0] - rc0), 64'd0);
    @(negedge clk); set_pin(1'b0);
    tick(LAT + 10);

    // Async reset during PRESS_WAIT, pin held pressed afterwards.
    @(negedge clk); set_pin(1'b1);
    tick(4);
    rc0 = rel_cnt[0]; pc0 = press_cnt[0];
    rst_pulse("rst_press_wait");
    c0 = cyc;
    repeat (LAT) @(negedge clk); #1;
    chk("rst_pw_press_a", 64'(out_press_a), 64'd1);
    chk("rst_pw_lat_a", 64'(last_press[0]), 64'(c0 + 1 + 7));
    chk("rst_pw_lat_b", 64'(last_press[1]), 64'(c0 + 1 + 7));
    chk("rst_pw_presses_a", 64'(press_cnt[0] - pc0), 64'd1);

    // Async reset while PRESSED: key drops at once, no release strobe.
    tick(5);
    pc0 = press_cnt[0];
    rst_pulse("rst_pressed");
    tick(LAT + 4);
    chk("rst_pressed_no_rel_a", 64'(rel_cnt[0] - rc0), 64'd0);
    chk("rst_pressed_no_rel_b", 64'(rel_cnt[1] - rc0), 64'd0);
    chk("rst_pressed_repress_a", 64'(press_cnt[0] - pc0), 64'd1);
    @(negedge clk); set_pin(1'b0);
    tick(LAT + 10);

    // Random bounce stress with occasional async resets.
    repeat (300) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) rst_pulse("rand_rst");
      set_pin(1'($urandom_range(0, 1)));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                         : int'($urandom_range(0, 4));
      tick(hold);
    end
    @(negedge clk); set_pin(1'b0);
    tick(LAT + 20);
    chk("drain_a", 64'(exp_q_a.size()), 64'd0);
    chk("drain_b", 64'(exp_q_b.size()), 64'd0);
    chk("final_key_a", 64'(out_key_a), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
